// File: rtl/seg7_scan_driver_if.sv
// Bundle between a display client and seg7_scan_driver: digit/attribute inputs with a
// load strobe, and the registered anode/cathode/frame outputs.
interface seg7_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   blank;
    logic [NUM_DIGITS-1:0]   blink;
    logic                    lz_suppress;
    logic                    load;
    logic [NUM_DIGITS-1:0]   anodes;
    logic [7:0]              cathodes;
    logic                    frame_done;

    modport master (
        output digits, dp, blank, blink, lz_suppress, load,
        input  anodes, cathodes, frame_done
    );

    modport slave (
        input  digits, dp, blank, blink, lz_suppress, load,
        output anodes, cathodes, frame_done
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver: refresh prescaler, hex decode, blink, blank,
// leading-zero suppression and a double buffer that only swaps at frame boundaries.
module seg7_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_TICKS = 256
) (
    input  logic  clk,
    input  logic  reset,
    seg7_if.slave bus
);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam int BW = $clog2(BLINK_TICKS + 1);
    localparam int DW = 4 * NUM_DIGITS;
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

    logic [PW-1:0]         presc;
    logic [IW-1:0]         idx;
    logic [IW-1:0]         idx_nxt;
    logic [BW-1:0]         blink_cnt;
    logic                  blink_off;
    logic                  blink_off_nxt;
    logic                  tick;
    logic                  wrap;
    logic                  commit;
    logic                  blink_wrap;

    logic [DW-1:0]         pend_digits;
    logic [NUM_DIGITS-1:0] pend_dp;
    logic [NUM_DIGITS-1:0] pend_blank;
    logic [NUM_DIGITS-1:0] pend_blink;
    logic                  pend_lz;
    logic                  pend_valid;

    logic [DW-1:0]         act_digits;
    logic [NUM_DIGITS-1:0] act_dp;
    logic [NUM_DIGITS-1:0] act_blank;
    logic [NUM_DIGITS-1:0] act_blink;
    logic                  act_lz;
    logic [DW-1:0]         act_digits_nxt;
    logic [NUM_DIGITS-1:0] act_dp_nxt;
    logic [NUM_DIGITS-1:0] act_blank_nxt;
    logic [NUM_DIGITS-1:0] act_blink_nxt;
    logic                  act_lz_nxt;

    logic                  zero_run;
    logic [NUM_DIGITS-1:0] suppressed;
    logic [3:0]            sel;
    logic                  dark;

    logic [NUM_DIGITS-1:0] anodes_p0;
    logic [7:0]            cathodes_p0;
    logic [NUM_DIGITS-1:0] anodes_p1;
    logic [7:0]            cathodes_p1;
    logic                  frame_done_p1;

    // Segments g..a, active-low, decimal point excluded.
    function automatic logic [6:0] hex_decode(input logic [3:0] v);
        case (v)
            4'h0:    hex_decode = 7'h40;
            4'h1:    hex_decode = 7'h79;
            4'h2:    hex_decode = 7'h24;
            4'h3:    hex_decode = 7'h30;
            4'h4:    hex_decode = 7'h19;
            4'h5:    hex_decode = 7'h12;
            4'h6:    hex_decode = 7'h02;
            4'h7:    hex_decode = 7'h78;
            4'h8:    hex_decode = 7'h00;
            4'h9:    hex_decode = 7'h10;
            4'hA:    hex_decode = 7'h08;
            4'hB:    hex_decode = 7'h03;
            4'hC:    hex_decode = 7'h46;
            4'hD:    hex_decode = 7'h21;
            4'hE:    hex_decode = 7'h06;
            default: hex_decode = 7'h0E;
        endcase
    endfunction

    always_comb begin
        tick          = (presc == PRESC_LAST);
        wrap          = tick && (idx == IDX_LAST);
        commit        = wrap && pend_valid;
        blink_wrap    = tick && (blink_cnt == BLINK_LAST);
        blink_off_nxt = blink_off ^ blink_wrap;
        idx_nxt       = idx;
        if (wrap) begin
            idx_nxt = '0;
        end else if (tick) begin
            idx_nxt = idx + 1'b1;
        end
        act_digits_nxt = commit ? pend_digits : act_digits;
        act_dp_nxt     = commit ? pend_dp     : act_dp;
        act_blank_nxt  = commit ? pend_blank  : act_blank;
        act_blink_nxt  = commit ? pend_blink  : act_blink;
        act_lz_nxt     = commit ? pend_lz     : act_lz;
    end

    // p0: the slot about to be shown is decoded from post-tick state, so a frame
    // swap is visible in its very first slot.
    always_comb begin
        zero_run   = 1'b1;
        suppressed = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_run      = zero_run && (act_digits_nxt[4*i +: 4] == 4'h0);
            suppressed[i] = act_lz_nxt && zero_run;
        end
        sel  = act_digits_nxt[4*idx_nxt +: 4];
        dark = act_blank_nxt[idx_nxt] | (act_blink_nxt[idx_nxt] & blink_off_nxt)
             | suppressed[idx_nxt];
        anodes_p0   = '1;
        cathodes_p0 = 8'hFF;
        if (!dark) begin
            anodes_p0[idx_nxt] = 1'b0;
            cathodes_p0        = {~act_dp_nxt[idx_nxt], hex_decode(sel)};
        end
    end

    // p1: pin registers update only on a slot tick.
    always_ff @(posedge clk) begin
        if (!reset) begin
            presc         <= '0;
            idx           <= '0;
            blink_cnt     <= '0;
            blink_off     <= 1'b0;
            pend_valid    <= 1'b0;
            pend_digits   <= '0;
            pend_dp       <= '0;
            pend_blank    <= '0;
            pend_blink    <= '0;
            pend_lz       <= 1'b0;
            act_digits    <= '0;
            act_dp        <= '0;
            act_blank     <= '1;
            act_blink     <= '0;
            act_lz        <= 1'b0;
            anodes_p1     <= '1;
            cathodes_p1   <= 8'hFF;
            frame_done_p1 <= 1'b0;
        end else begin
            presc         <= tick ? '0 : presc + 1'b1;
            idx           <= idx_nxt;
            blink_off     <= blink_off_nxt;
            frame_done_p1 <= wrap;
            if (tick) begin
                blink_cnt   <= blink_wrap ? '0 : blink_cnt + 1'b1;
                anodes_p1   <= anodes_p0;
                cathodes_p1 <= cathodes_p0;
            end
            act_digits <= act_digits_nxt;
            act_dp     <= act_dp_nxt;
            act_blank  <= act_blank_nxt;
            act_blink  <= act_blink_nxt;
            act_lz     <= act_lz_nxt;
            // A load coinciding with a commit refills pending after the old contents move out.
            if (bus.load) begin
                pend_digits <= bus.digits;
                pend_dp     <= bus.dp;
                pend_blank  <= bus.blank;
                pend_blink  <= bus.blink;
                pend_lz     <= bus.lz_suppress;
                pend_valid  <= 1'b1;
            end else if (commit) begin
                pend_valid <= 1'b0;
            end
        end
    end

    assign bus.anodes     = anodes_p1;
    assign bus.cathodes   = cathodes_p1;
    assign bus.frame_done = frame_done_p1;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed plus randomized bench for seg7_scan_driver with a count-based display model.
module tb_seg7_scan_driver;
    localparam int N  = 4;
    localparam int RD = 4;
    localparam int BT = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    seg7_if #(.NUM_DIGITS(N)) bus ();

    seg7_scan_driver #(
        .NUM_DIGITS (N),
        .REFRESH_DIV(RD),
        .BLINK_TICKS(BT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Model state: edges since reset, active and pending buffers, expected pins.
    int          e = 0;
    bit [4*N-1:0] m_dig, p_dig;
    bit [N-1:0]  m_dp, m_bl, m_bk, p_dp, p_bl, p_bk;
    bit          m_lz, p_lz, p_v;
    logic [N-1:0] exp_an;
    logic [7:0]  exp_ca;
    logic        exp_fd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    task automatic show(input int i, input bit off);
        bit supp, dk;
        logic [3:0] h;
        supp = m_lz && (i > 0) && ((m_dig >> (4 * i)) == '0);
        dk   = m_bl[i] || (m_bk[i] && off) || supp;
        h    = m_dig[4*i +: 4];
        if (dk) begin
            exp_an = '1;
            exp_ca = 8'hFF;
        end else begin
            exp_an = ~(4'b0001 << i);
            exp_ca = {~m_dp[i], seg_tab[h][6:0]};
        end
    endtask

    task automatic model_edge();
        int t, i;
        bit committed;
        committed = 1'b0;
        if (!reset) begin
            e = 0; p_v = 0;
            m_dig = '0; m_dp = '0; m_bk = '0; m_bl = '1; m_lz = 0;
            exp_an = '1; exp_ca = 8'hFF; exp_fd = 1'b0;
        end else begin
            e++;
            exp_fd = 1'b0;
            if (e % RD == 0) begin
                t = e / RD;
                i = t % N;
                if (i == 0) begin
                    exp_fd = 1'b1;
                    if (p_v) begin
                        m_dig = p_dig; m_dp = p_dp; m_bl = p_bl; m_bk = p_bk; m_lz = p_lz;
                        committed = 1'b1;
                    end
                end
                show(i, ((t / BT) % 2) == 1);
            end
            if (bus.load) begin
                p_dig = bus.digits; p_dp = bus.dp; p_bl = bus.blank; p_bk = bus.blink;
                p_lz = bus.lz_suppress; p_v = 1'b1;
            end else if (committed) begin
                p_v = 1'b0;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check("anodes", 32'(bus.anodes), 32'(exp_an));
        check("cathodes", 32'(bus.cathodes), 32'(exp_ca));
        check("frame_done", 32'(bus.frame_done), 32'(exp_fd));
    endtask

    task automatic drive(input logic [15:0] d, input logic [3:0] p, input logic [3:0] bl,
                         input logic [3:0] bk, input logic lz);
        bus.digits = d; bus.dp = p; bus.blank = bl; bus.blink = bk; bus.lz_suppress = lz;
    endtask

    task automatic load_pulse();
        bus.load = 1'b1;
        cycle();
        bus.load = 1'b0;
    endtask

    task automatic wait_wrap();
        bit found;
        found = 1'b0;
        for (int k = 0; k < 200; k++) begin
            cycle();
            if (exp_fd) begin
                found = 1'b1;
                break;
            end
        end
        check("wrap_timeout", 32'(found), 32'd1);
    endtask

    // Slot s expectations live in an_all[4s+:4] / ca_all[8s+:8].
    task automatic check_slots(input string tag, input logic [15:0] an_all, input logic [31:0] ca_all);
        for (int s = 0; s < N; s++) begin
            check({tag, "_an"}, 32'(bus.anodes), 32'(an_all[4*s +: 4]));
            check({tag, "_ca"}, 32'(bus.cathodes), 32'(ca_all[8*s +: 8]));
            repeat (RD) cycle();
        end
    endtask

    initial begin
        int k, lit;
        logic [15:0] d;
        bus.load = 1'b0;
        drive(16'h0000, 4'h0, 4'h0, 4'h0, 1'b0);

        reset = 1'b0;
        repeat (3) cycle();
        check("rst_anodes", 32'(bus.anodes), 32'hF);
        check("rst_cathodes", 32'(bus.cathodes), 32'hFF);
        check("rst_frame_done", 32'(bus.frame_done), 32'h0);
        reset = 1'b1;
        repeat (40) cycle();
        check("noload_dark", 32'(bus.anodes), 32'hF);

        drive(16'h1234, 4'h0, 4'h0, 4'h0, 1'b0);
        repeat ($urandom_range(0, 5)) cycle();
        load_pulse();
        wait_wrap();
        check_slots("hex1234", 16'h7BDE, 32'hF9A4B099);
        k = 0;
        do begin
            cycle();
            k++;
        end while (!bus.frame_done && k < 40);
        check("frame_period", 32'(k), 32'd16);

        drive(16'h0050, 4'h0, 4'h0, 4'h0, 1'b1);
        load_pulse();
        wait_wrap();
        check_slots("lz_on", 16'hFFDE, 32'hFFFF92C0);
        drive(16'h0050, 4'h0, 4'h0, 4'h0, 1'b0);
        load_pulse();
        wait_wrap();
        check_slots("lz_off", 16'h7BDE, 32'hC0C092C0);

        drive(16'h0008, 4'b0010, 4'h0, 4'h0, 1'b0);
        load_pulse();
        wait_wrap();
        check_slots("dp", 16'h7BDE, 32'hC0C04080);

        drive(16'h1234, 4'h0, 4'h0, 4'b0001, 1'b0);
        load_pulse();
        wait_wrap();
        lit = 0;
        for (int f = 0; f < 16; f++) begin
            if (bus.anodes == 4'hE) lit++;
            repeat (N * RD) cycle();
        end
        check("blink_lit_slots", 32'(lit), 32'd8);

        drive(16'hAAAA, 4'h0, 4'h0, 4'h0, 1'b0);
        repeat (5) cycle();
        load_pulse();
        k = 0;
        while (!(((e + 1) % RD == 0) && (((e + 1) / RD) % N == 0)) && k < 40) begin
            cycle();
            k++;
        end
        check("commit_align", 32'(k < 40), 32'd1);
        drive(16'hBBBB, 4'h0, 4'h0, 4'h0, 1'b0);
        load_pulse();
        check_slots("dbuf_old", 16'h7BDE, 32'h88888888);
        check_slots("dbuf_new", 16'h7BDE, 32'h83838383);

        for (int c = 0; c < 800; c++) begin
            d = 16'($urandom);
            case ($urandom_range(0, 3))
                0: d = d & 16'h000F;
                1: d = d & 16'h00FF;
                default: ;
            endcase
            drive(d, 4'($urandom),
                  ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0,
                  4'($urandom), 1'($urandom));
            bus.load = ($urandom_range(0, 7) == 0);
            cycle();
        end
        bus.load = 1'b0;

        drive(16'h9876, 4'hF, 4'h0, 4'h0, 1'b0);
        load_pulse();
        repeat (6) cycle();
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        repeat (40) cycle();
        check("post_reset_dark", 32'(bus.anodes), 32'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
